mem_copy_engine: RTL and testbench

- Initiator-side engine for the single-port, byte-wide data memory: combinational read, synchronous write, one access per cycle.
- On a one-cycle Start command it performs a block copy (memmove semantics, overlap-safe) or a block fill over the memory port, then pulses Done.
- It sits between the control/decode logic and the data memory and owns the memory address, write-enable and write-data lines while Busy.

---
 rtl/mem_copy_pkg.sv | 5 +
 rtl/mem_copy_engine.sv | 81 ++++++++
 tb/tb_mem_copy_engine.sv | 176 +++++++++++++++++
 3 files changed

// File: rtl/mem_copy_pkg.sv
// mem_copy_pkg: shared state and opcode types for the memory copy/fill engine
package mem_copy_pkg;
  typedef enum logic [1:0] {IDLE, READ, WRITE, FINISH} state_t;
  typedef enum logic {OP_COPY = 1'b0, OP_FILL = 1'b1} op_t;
endpackage

// File: rtl/mem_copy_engine.sv
// mem_copy_engine: overlap-safe block copy / block fill over a single-port byte memory
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int W = 8,
  parameter int A = 8
) (
  input  logic         Clk,
  input  logic         Reset,
  input  logic         Start,
  input  logic         Op,
  input  logic [A-1:0] SrcAddr,
  input  logic [A-1:0] DstAddr,
  input  logic [A-1:0] Len,
  input  logic [W-1:0] FillValue,
  output logic [A-1:0] MemAddr,
  output logic         MemWriteEn,
  output logic [W-1:0] MemWData,
  input  logic [W-1:0] MemRData,
  output logic         Busy,
  output logic         Done
);
  state_t state, state_nxt;
  op_t op;
  logic back, back_nxt;
  logic [A-1:0] cnt, src, dst, d, ofs, step;
  logic [W-1:0] data_buf, fill;
  assign d = DstAddr - SrcAddr;
  assign back_nxt = !Op && d != '0 && d < Len;
  assign ofs = back_nxt ? Len - A'(1) : '0;
  assign step = back ? '1 : A'(1);
  assign MemAddr = state == READ ? src : state == WRITE ? dst : '0;
  assign MemWriteEn = state == WRITE;
  assign MemWData = state == WRITE ? (op == OP_FILL ? fill : data_buf) : '0;
  assign Busy = state != IDLE;
  assign Done = state == FINISH;
  // state register
  always_ff @(posedge Clk) state <= Reset ? IDLE : state_nxt;
  // next-state decode; a fill never revisits READ
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = !Start ? IDLE : Len == '0 ? FINISH : Op ? WRITE : READ;
      READ:    state_nxt = WRITE;
      WRITE:   state_nxt = cnt == A'(1) ? FINISH : op == OP_FILL ? WRITE : READ;
      default: state_nxt = IDLE;
    endcase
  end
  // command latch, byte buffer, pointers and remaining count
  always_ff @(posedge Clk) begin
    if (Reset) begin
      op <= OP_COPY;
      back <= 1'b0;
      cnt <= '0;
      src <= '0;
      dst <= '0;
      data_buf <= '0;
      fill <= '0;
    end else begin
      case (state)
        IDLE: if (Start) begin
          op <= op_t'(Op);
          back <= back_nxt;
          cnt <= Len;
          fill <= FillValue;
          src <= SrcAddr + ofs;
          dst <= DstAddr + ofs;
        end
        READ: begin
          data_buf <= MemRData;
          src <= src + step;
        end
        WRITE: begin
          dst <= dst + step;
          cnt <= cnt - A'(1);
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_copy_engine.sv
// tb_mem_copy_engine: directed checks of copy, overlap, fill, wrap, no-op, busy-start and reset
module tb_mem_copy_engine;
  logic       Clk = 0;
  logic       Reset = 1;
  logic       Start = 0;
  logic       Op = 0;
  logic [7:0] SrcAddr = 0;
  logic [7:0] DstAddr = 0;
  logic [7:0] Len = 0;
  logic [7:0] FillValue = 0;
  logic [7:0] MemAddr, MemWData, MemRData;
  logic       MemWriteEn, Busy, Done;
  logic [7:0] mem [256];
  int n_tests = 0, n_fail = 0;
  int wr_cnt = 0, cyc = 0;
  logic [7:0] first_wr;
  logic first_seen = 0, done_seen = 0;
  logic [7:0] rd_log [$];

  mem_copy_engine #(.W(8), .A(8)) dut (
    .Clk(Clk), .Reset(Reset), .Start(Start), .Op(Op), .SrcAddr(SrcAddr),
    .DstAddr(DstAddr), .Len(Len), .FillValue(FillValue), .MemAddr(MemAddr),
    .MemWriteEn(MemWriteEn), .MemWData(MemWData), .MemRData(MemRData),
    .Busy(Busy), .Done(Done)
  );

  always #5 Clk = ~Clk;
  assign MemRData = mem[MemAddr];

  always @(posedge Clk) begin
    if (MemWriteEn) begin
      mem[MemAddr] <= MemWData;
      wr_cnt <= wr_cnt + 1;
      if (!first_seen) begin
        first_wr <= MemAddr;
        first_seen <= 1;
      end
    end
    if (Busy && !MemWriteEn && !Done) rd_log.push_back(MemAddr);
    if (Done) done_seen <= 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic launch(input logic op, input logic [7:0] s, d, l, f);
    wr_cnt = 0;
    first_seen = 0;
    done_seen = 0;
    rd_log.delete();
    Op = op; SrcAddr = s; DstAddr = d; Len = l; FillValue = f; Start = 1;
    tick();
    Start = 0; Op = ~op; SrcAddr = 8'h5A; DstAddr = 8'hA5; Len = 8'h77; FillValue = 8'h99;
    cyc = 1;
  endtask

  task automatic wait_done();
    while (!Done && cyc < 600) begin
      tick();
      cyc++;
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 0;
    tick(); tick();
    Reset = 0;
    chk("rst_addr", MemAddr, 0);
    chk("rst_we", MemWriteEn, 0);
    chk("rst_wdata", MemWData, 0);
    chk("rst_busy", Busy, 0);
    chk("rst_done", Done, 0);
    // copy without overlap
    mem[8'h10] = 8'h11; mem[8'h11] = 8'h22; mem[8'h12] = 8'h33; mem[8'h13] = 8'h44;
    launch(0, 8'h10, 8'h40, 4, 0);
    chk("cp_busy", Busy, 1);
    wait_done();
    chk("cp_done_cyc", cyc, 9);
    chk("cp_wr_cnt", wr_cnt, 4);
    chk("cp_m40", mem[8'h40], 8'h11);
    chk("cp_m41", mem[8'h41], 8'h22);
    chk("cp_m42", mem[8'h42], 8'h33);
    chk("cp_m43", mem[8'h43], 8'h44);
    tick();
    chk("cp_busy_after", Busy, 0);
    chk("cp_done_after", Done, 0);
    // overlapping copy must run backward
    for (int i = 0; i < 6; i++) mem[8'h20 + i] = 8'(i + 1);
    launch(0, 8'h20, 8'h22, 4, 0);
    wait_done();
    chk("ov_done_cyc", cyc, 9);
    chk("ov_first_wr", first_wr, 8'h25);
    chk("ov_m20", mem[8'h20], 1);
    chk("ov_m21", mem[8'h21], 2);
    chk("ov_m22", mem[8'h22], 1);
    chk("ov_m23", mem[8'h23], 2);
    chk("ov_m24", mem[8'h24], 3);
    chk("ov_m25", mem[8'h25], 4);
    tick();
    // fill
    mem[8'h83] = 8'h55;
    launch(1, 8'h00, 8'h80, 3, 8'hAA);
    wait_done();
    chk("fl_done_cyc", cyc, 4);
    chk("fl_wr_cnt", wr_cnt, 3);
    chk("fl_m80", mem[8'h80], 8'hAA);
    chk("fl_m81", mem[8'h81], 8'hAA);
    chk("fl_m82", mem[8'h82], 8'hAA);
    chk("fl_m83", mem[8'h83], 8'h55);
    tick();
    // source wraps FF->00
    mem[8'hFE] = 8'hA1; mem[8'hFF] = 8'hA2; mem[8'h00] = 8'hA3; mem[8'h01] = 8'hA4;
    launch(0, 8'hFE, 8'h10, 4, 0);
    wait_done();
    chk("wr_rd_len", rd_log.size(), 4);
    if (rd_log.size() == 4) begin
      chk("wr_rd0", rd_log[0], 8'hFE);
      chk("wr_rd1", rd_log[1], 8'hFF);
      chk("wr_rd2", rd_log[2], 8'h00);
      chk("wr_rd3", rd_log[3], 8'h01);
    end
    chk("wr_m10", mem[8'h10], 8'hA1);
    chk("wr_m11", mem[8'h11], 8'hA2);
    chk("wr_m12", mem[8'h12], 8'hA3);
    chk("wr_m13", mem[8'h13], 8'hA4);
    tick();
    // zero length is a no-op
    launch(0, 8'h10, 8'h50, 0, 0);
    chk("z_done", Done, 1);
    tick();
    chk("z_busy_after", Busy, 0);
    chk("z_wr_cnt", wr_cnt, 0);
    // Start while busy is ignored
    launch(0, 8'h10, 8'h60, 3, 0);
    tick(); tick(); cyc = 3;
    Start = 1; Op = 1; Len = 8; DstAddr = 8'h61; FillValue = 8'hEE;
    tick(); cyc++;
    Start = 0;
    wait_done();
    chk("bs_done_cyc", cyc, 7);
    chk("bs_wr_cnt", wr_cnt, 3);
    chk("bs_m60", mem[8'h60], 8'hA1);
    chk("bs_m61", mem[8'h61], 8'hA2);
    chk("bs_m62", mem[8'h62], 8'hA3);
    chk("bs_m63", mem[8'h63], 0);
    tick();
    // reset after two of eight bytes
    for (int i = 0; i < 8; i++) mem[8'h30 + i] = 8'(8'hC0 + i);
    launch(0, 8'h30, 8'h70, 8, 0);
    tick(); tick(); tick(); tick();
    Reset = 1;
    tick();
    Reset = 0;
    chk("rm_busy", Busy, 0);
    chk("rm_we", MemWriteEn, 0);
    chk("rm_done", Done, 0);
    for (int i = 0; i < 20; i++) tick();
    chk("rm_done_seen", done_seen, 0);
    chk("rm_wr_cnt", wr_cnt, 2);
    chk("rm_m70", mem[8'h70], 8'hC0);
    chk("rm_m71", mem[8'h71], 8'hC1);
    chk("rm_m72", mem[8'h72], 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
